// File: rtl/fill_line_sequencer_pkg.sv
// Shared types and default widths for the fill-line sequencer.
package fill_line_sequencer_pkg;

  localparam int PILL_W_DEF  = 6;
  localparam int BATCH_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_BOTTLE = 3'd1,
    ST_FILL        = 3'd2,
    ST_ADVANCE     = 3'd3,
    ST_DONE        = 3'd4,
    ST_FAULT       = 3'd5
  } state_e;

endpackage

// File: rtl/fill_line_sequencer_interval_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module fill_interval_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/fill_line_sequencer.sv
// Fill-station sequencer: wait bottle, fill to target, index conveyor, repeat per batch.
// Define FILL_TIMEOUT_EN to add a pill-gap watchdog in FILL (shares the conveyor timer).
module fill_line_sequencer
  import fill_line_sequencer_pkg::*;
#(
  parameter int PILL_W         = PILL_W_DEF,
  parameter int BATCH_W        = BATCH_W_DEF,
  parameter int CONV_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [PILL_W-1:0]  pills_per_bottle,
  input  logic [BATCH_W-1:0] bottles_per_batch,
  input  logic               bottle_present,
  input  logic               pill_pulse,
  output logic               valve_open,
  output logic               conveyor_run,
  output logic               bottle_done,
  output logic               batch_done,
  output logic               busy,
  output logic               fault,
  output logic [PILL_W-1:0]  pills_in_bottle,
  output logic [BATCH_W-1:0] bottles_filled
);

  localparam int TMR_MAX = (CONV_CYCLES > TIMEOUT_CYCLES) ? CONV_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] CONV_LOAD = TMR_W'(CONV_CYCLES - 1);
`ifdef FILL_TIMEOUT_EN
  localparam logic [TMR_W-1:0] WD_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
`endif

  state_e             state_q, state_d;
  logic [PILL_W-1:0]  pills_q, pills_d, pills_inc;
  logic [BATCH_W-1:0] bottles_q, bottles_d;
  logic [PILL_W-1:0]  tgt_pills_q, tgt_pills_d;
  logic [BATCH_W-1:0] tgt_bottles_q, tgt_bottles_d;
  logic valve_q, valve_d, conv_q, conv_d, bdone_q, bdone_d;
  logic batch_q, batch_d, busy_q, busy_d, fault_q, fault_d;
  logic             tmr_load, tmr_dec, tmr_done;
  logic [TMR_W-1:0] tmr_val;

  fill_interval_timer #(.CNT_W(TMR_W)) u_timer (
    .clk      (clk),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  assign pills_inc = pills_q + PILL_W'(1);

  always_comb begin
    state_d       = state_q;
    pills_d       = pills_q;
    bottles_d     = bottles_q;
    tgt_pills_d   = tgt_pills_q;
    tgt_bottles_d = tgt_bottles_q;
    bdone_d       = 1'b0;
    tmr_load      = 1'b0;
    tmr_val       = CONV_LOAD;
    tmr_dec       = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && (pills_per_bottle != '0) && (bottles_per_batch != '0)) begin
            tgt_pills_d   = pills_per_bottle;
            tgt_bottles_d = bottles_per_batch;
            pills_d       = '0;
            bottles_d     = '0;
            state_d       = ST_WAIT_BOTTLE;
          end
        end
        ST_WAIT_BOTTLE: begin
          if (bottle_present) begin
            state_d = ST_FILL;
`ifdef FILL_TIMEOUT_EN
            tmr_load = 1'b1;
            tmr_val  = WD_LOAD;
`endif
          end
        end
        ST_FILL: begin
          // A pill on the same edge the bottle vanishes still counts; fault follows next cycle.
          if (pill_pulse) begin
            pills_d = pills_inc;
            if (pills_inc == tgt_pills_q) begin
              pills_d   = '0;
              bottles_d = bottles_q + BATCH_W'(1);
              bdone_d   = 1'b1;
              tmr_load  = 1'b1;
              state_d   = ST_ADVANCE;
            end else begin
`ifdef FILL_TIMEOUT_EN
              tmr_load = 1'b1;
              tmr_val  = WD_LOAD;
`endif
            end
          end else if (!bottle_present) begin
            state_d = ST_FAULT;
          end else begin
`ifdef FILL_TIMEOUT_EN
            if (tmr_done) state_d = ST_FAULT;
            else          tmr_dec = 1'b1;
`endif
          end
        end
        ST_ADVANCE: begin
          if (tmr_done) begin
            state_d = (bottles_q == tgt_bottles_q) ? ST_DONE : ST_WAIT_BOTTLE;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        ST_DONE:  state_d = ST_IDLE;
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_IDLE;
      endcase
    end
    valve_d = (state_d == ST_FILL);
    conv_d  = (state_d == ST_ADVANCE);
    batch_d = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pills_q   <= '0;
      bottles_q <= '0;
      valve_q   <= 1'b0;
      conv_q    <= 1'b0;
      bdone_q   <= 1'b0;
      batch_q   <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pills_q   <= pills_d;
      bottles_q <= bottles_d;
      valve_q   <= valve_d;
      conv_q    <= conv_d;
      bdone_q   <= bdone_d;
      batch_q   <= batch_d;
      busy_q    <= busy_d;
      fault_q   <= fault_d;
    end
  end

  // Batch targets are only consumed after a start has loaded them.
  always_ff @(posedge clk) begin
    tgt_pills_q   <= tgt_pills_d;
    tgt_bottles_q <= tgt_bottles_d;
  end

  assign valve_open      = valve_q;
  assign conveyor_run    = conv_q;
  assign bottle_done     = bdone_q;
  assign batch_done      = batch_q;
  assign busy            = busy_q;
  assign fault           = fault_q;
  assign pills_in_bottle = pills_q;
  assign bottles_filled  = bottles_q;

endmodule
